// File: rtl/lifo_stack_if.sv
// Handshake/data bundle between a LIFO stack and its user.
// The user side drives the request signals; the stack answers with registered status and data.
interface lifo_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, pop, din,
        input  dout, empty, full, count, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, din,
        output dout, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with push, pop, replace-top and synchronous clear.
// All outputs are registered; rejected operations raise one-cycle error pulses.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    lifo_stack_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             we;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        we      = 1'b0;
        wr_idx  = AW'(count_q);
        // Entry that becomes the new top after a pop.
        rd_idx  = AW'(count_q - CNT_W'(2));

        if (bus.clear) begin
            count_d = '0;
            dout_d  = '0;
        end else if (bus.push && bus.pop && !empty_q) begin
            we      = 1'b1;
            wr_idx  = AW'(count_q - CNT_W'(1));
            dout_d  = bus.din;
        end else if (bus.push && (!bus.pop || empty_q)) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                we      = 1'b1;
                count_d = count_q + CNT_W'(1);
                dout_d  = bus.din;
            end
        end else if (bus.pop) begin
            if (empty_q) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
                dout_d  = (count_q == CNT_W'(1)) ? '0 : mem[rd_idx];
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            dout_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage has no reset; only accepted writes ever touch it.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[wr_idx] <= bus.din;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_lifo_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] model_q[$];
    bit               m_ovf;
    bit               m_unf;

    task automatic model_apply(input bit r, input bit c, input bit ps, input bit pp,
                               input logic [WIDTH-1:0] d);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (!r || c) begin
            model_q.delete();
        end else if (ps && pp) begin
            if (model_q.size() == 0) model_q.push_back(d);
            else model_q[model_q.size()-1] = d;
        end else if (ps) begin
            if (model_q.size() == DEPTH) m_ovf = 1'b1;
            else model_q.push_back(d);
        end else if (pp) begin
            if (model_q.size() == 0) m_unf = 1'b1;
            else void'(model_q.pop_back());
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_dout();
        return (model_q.size() == 0) ? '0 : model_q[model_q.size()-1];
    endfunction

    // One clock with the given controls; returns 1 ns after the edge.
    task automatic cycle(input bit r, input bit c, input bit ps, input bit pp,
                         input logic [WIDTH-1:0] d);
        rst_n     = r;
        bus.clear = c;
        bus.push  = ps;
        bus.pop   = pp;
        bus.din   = d;
        @(posedge clk);
        model_apply(r, c, ps, pp, d);
        #1;
        rst_n     = 1'b1;
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.count !== '0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", bus.count);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", bus.empty, bus.full);
        end
        checks++;
        if (bus.dout !== '0) begin
            errors++; $display("FAIL reset_dout got=%h exp=00", bus.dout);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got ovf=%b unf=%b exp 0 0", bus.overflow, bus.underflow);
        end
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] exp_d [6] = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h11, 8'h00};
        int               exp_c [6] = '{1, 2, 3, 2, 1, 0};
        logic [WIDTH-1:0] vals  [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cycle(1'b1, 1'b0, 1'b1, 1'b0, vals[i]);
            else       cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
            checks++;
            if (bus.dout !== exp_d[i] || bus.count !== CNT_W'(exp_c[i])) begin
                errors++;
                $display("FAIL push_pop step%0d got dout=%h count=%0d exp dout=%h count=%0d",
                         i, bus.dout, bus.count, exp_d[i], exp_c[i]);
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++; $display("FAIL push_pop_empty got=%b exp=1", bus.empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.dout !== 8'hA3 || bus.count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL overflow got full=%b ovf=%b dout=%h count=%0d exp 1 1 a3 4",
                     bus.full, bus.overflow, bus.dout, bus.count);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
        checks++;
        if (bus.overflow !== 1'b1 || bus.dout !== 8'hA3) begin
            errors++; $display("FAIL overflow_repeat got ovf=%b dout=%h exp 1 a3", bus.overflow, bus.dout);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
        checks++;
        if (bus.dout !== 8'h55 || bus.count !== CNT_W'(4) || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL replace_full got dout=%h count=%0d ovf=%b exp 55 4 0", bus.dout, bus.count, bus.overflow);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.dout !== 8'hA2 || bus.count !== CNT_W'(3) || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL pop_after_full got dout=%h count=%0d full=%b exp a2 3 0", bus.dout, bus.count, bus.full);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_underflow();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.underflow !== 1'b1 || bus.count !== '0) begin
            errors++; $display("FAIL underflow got unf=%b count=%0d exp 1 0", bus.underflow, bus.count);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++; $display("FAIL underflow_repeat got=%b exp=1", bus.underflow);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        checks++;
        if (bus.count !== CNT_W'(1) || bus.dout !== 8'h77 || bus.underflow !== 1'b0 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_empty got count=%0d dout=%h unf=%b empty=%b exp 1 77 0 0",
                     bus.count, bus.dout, bus.underflow, bus.empty);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.underflow !== 1'b0 || bus.dout !== 8'h77) begin
            errors++; $display("FAIL hold got unf=%b dout=%h exp 0 77", bus.underflow, bus.dout);
        end
    endtask

    task automatic test_clear();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h40 + 8'(i));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
        checks++;
        if (bus.count !== '0 || bus.empty !== 1'b1 || bus.dout !== '0 ||
            bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL clear got count=%0d empty=%b dout=%h ovf=%b unf=%b exp 0 1 00 0 0",
                     bus.count, bus.empty, bus.dout, bus.overflow, bus.underflow);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++; $display("FAIL clear_then_pop got unf=%b exp=1", bus.underflow);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.count !== '0 || bus.underflow !== 1'b0 || bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_mid got count=%0d unf=%b dout=%h exp 0 0 00", bus.count, bus.underflow, bus.dout);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++; $display("FAIL reset_then_pop got unf=%b exp=1", bus.underflow);
        end
    endtask

    task automatic test_random();
        bit r, c, ps, pp;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) != 0);
            c  = ($urandom_range(0, 29) == 0);
            ps = ($urandom_range(0, 1) == 1);
            pp = ($urandom_range(0, 2) == 0);
            cycle(r, c, ps, pp, 8'($urandom));
            checks++;
            if (bus.dout !== exp_dout() || bus.count !== CNT_W'(model_q.size()) ||
                bus.empty !== (model_q.size() == 0) || bus.full !== (model_q.size() == DEPTH) ||
                bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                errors++;
                $display("FAIL random cyc%0d got dout=%h cnt=%0d e=%b f=%b o=%b u=%b exp dout=%h cnt=%0d o=%b u=%b",
                         i, bus.dout, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow,
                         exp_dout(), model_q.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.din   = '0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
